// File: rtl/video_timing_rx_if.sv
// Raw video stream into the timing receiver: active-low syncs, data enable and RGB.
// The stream has no backpressure: every cycle with valid high is one pixel, taken unconditionally.
interface video_timing_rx_if;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output hsync, vsync, valid, red, green, blue);
    modport slave  (input  hsync, vsync, valid, red, green, blue);
endinterface

// File: rtl/video_timing_rx.sv
// Receive-side timing recovery: registers the pixel stream with x/y coordinates and
// frame/line markers, measures line and frame geometry, and qualifies format lock.
module video_timing_rx #(
    parameter int ACTIVE_H    = 800,
    parameter int ACTIVE_V    = 600,
    parameter int TOTAL_H     = 1056,
    parameter int TOTAL_V     = 628,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic                clk,
    input  logic                rst,
    video_timing_rx_if.slave    video_i,
    output logic                pix_valid_o,
    output logic [7:0]          red_o,
    output logic [7:0]          green_o,
    output logic [7:0]          blue_o,
    output logic [CW-1:0]       x_o,
    output logic [CW-1:0]       y_o,
    output logic                sof_o,
    output logic                eol_o,
    output logic [CW-1:0]       meas_h_total_o,
    output logic [CW-1:0]       meas_h_active_o,
    output logic [CW-1:0]       meas_v_total_o,
    output logic [CW-1:0]       meas_v_active_o,
    output logic                locked_o,
    output logic                fmt_err_o,
    output logic                lost_lock_o,
    output logic [1:0]          dbg_state_o
);
    localparam int MW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    logic          hs_prev_q, vs_prev_q, de_prev_q;
    logic          hs_fall, vs_fall, de_fall;
    logic [CW-1:0] h_cnt_q, h_cnt_d, h_tot_w_q, h_tot_w_d, h_act_w_q, h_act_w_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, av_cnt_q, av_cnt_d;
    logic [CW-1:0] meas_ht_q, meas_ht_d, meas_ha_q, meas_ha_d;
    logic [CW-1:0] meas_vt_q, meas_vt_d, meas_va_q, meas_va_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          sof_q, sof_d, eol_q, eol_d, pix_valid_q;
    logic [7:0]    red_q, green_q, blue_q;
    logic          fmt_match, timeout;
    state_e        state_q;
    logic [MW-1:0] match_q;
    logic          locked_q, err_q, lost_q;

    assign hs_fall = hs_prev_q & ~video_i.hsync;
    assign vs_fall = vs_prev_q & ~video_i.vsync;
    assign de_fall = de_prev_q & ~video_i.valid;

    // Line end is folded in before frame end so a coincident hs/vs fall counts the last line.
    always_comb begin
        h_cnt_d    = hs_fall ? CW'(1) : sat_inc(h_cnt_q);
        h_tot_w_d  = hs_fall ? h_cnt_q : h_tot_w_q;
        h_act_w_d  = de_fall ? pix_cnt_q : h_act_w_q;
        if (video_i.valid)  pix_cnt_d = sat_inc(pix_cnt_q);
        else if (de_fall)   pix_cnt_d = '0;
        else                pix_cnt_d = pix_cnt_q;
        line_cnt_d = hs_fall ? sat_inc(line_cnt_q) : line_cnt_q;
        av_cnt_d   = de_fall ? sat_inc(av_cnt_q) : av_cnt_q;
        meas_ht_d  = meas_ht_q;
        meas_ha_d  = meas_ha_q;
        meas_vt_d  = meas_vt_q;
        meas_va_d  = meas_va_q;
        if (vs_fall) begin
            meas_ht_d  = h_tot_w_d;
            meas_ha_d  = h_act_w_d;
            meas_vt_d  = line_cnt_d;
            meas_va_d  = av_cnt_d;
            line_cnt_d = '0;
            av_cnt_d   = '0;
        end
        x_d = x_q;
        y_d = y_q;
        if (video_i.valid) begin
            x_d = de_prev_q ? sat_inc(x_q) : '0;
            y_d = vs_fall ? '0 : av_cnt_q;
        end
        sof_d = video_i.valid && (x_d == '0) && (y_d == '0);
        eol_d = video_i.valid && (x_d == CW'(ACTIVE_H - 1));
    end

    assign fmt_match = (meas_ht_d == CW'(TOTAL_H)) && (meas_ha_d == CW'(ACTIVE_H)) &&
                       (meas_vt_d == CW'(TOTAL_V)) && (meas_va_d == CW'(ACTIVE_V));
    assign timeout   = (line_cnt_q > CW'(2 * TOTAL_V)) && !vs_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            de_prev_q <= 1'b0;
            h_cnt_q <= '0; h_tot_w_q <= '0; h_act_w_q <= '0;
            pix_cnt_q <= '0; line_cnt_q <= '0; av_cnt_q <= '0;
            meas_ht_q <= '0; meas_ha_q <= '0; meas_vt_q <= '0; meas_va_q <= '0;
            x_q <= '0; y_q <= '0; sof_q <= 1'b0; eol_q <= 1'b0; pix_valid_q <= 1'b0;
            red_q <= '0; green_q <= '0; blue_q <= '0;
        end else begin
            hs_prev_q <= video_i.hsync;
            vs_prev_q <= video_i.vsync;
            de_prev_q <= video_i.valid;
            h_cnt_q <= h_cnt_d; h_tot_w_q <= h_tot_w_d; h_act_w_q <= h_act_w_d;
            pix_cnt_q <= pix_cnt_d; line_cnt_q <= line_cnt_d; av_cnt_q <= av_cnt_d;
            meas_ht_q <= meas_ht_d; meas_ha_q <= meas_ha_d; meas_vt_q <= meas_vt_d; meas_va_q <= meas_va_d;
            x_q <= x_d; y_q <= y_d; sof_q <= sof_d; eol_q <= eol_d; pix_valid_q <= video_i.valid;
            red_q <= video_i.red; green_q <= video_i.green; blue_q <= video_i.blue;
        end
    end

    // Lock qualification; a missing vsync (timeout) overrides any frame decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            match_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            if (timeout) begin
                state_q  <= IDLE;
                match_q  <= '0;
                locked_q <= 1'b0;
                lost_q   <= (state_q == LOCKED);
            end else if (vs_fall) begin
                case (state_q)
                    IDLE: begin
                        state_q <= MEASURE;
                        match_q <= '0;
                    end
                    MEASURE: begin
                        if (fmt_match) begin
                            err_q <= 1'b0;
                            if (match_q == MW'(LOCK_FRAMES - 1)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= MW'(LOCK_FRAMES);
                            end else begin
                                match_q <= match_q + MW'(1);
                            end
                        end else begin
                            match_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (fmt_match) begin
                            err_q <= 1'b0;
                        end else begin
                            state_q  <= MEASURE;
                            locked_q <= 1'b0;
                            match_q  <= '0;
                            err_q    <= 1'b1;
                            lost_q   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pix_valid_o     = pix_valid_q;
    assign red_o           = red_q;
    assign green_o         = green_q;
    assign blue_o          = blue_q;
    assign x_o             = x_q;
    assign y_o             = y_q;
    assign sof_o           = sof_q;
    assign eol_o           = eol_q;
    assign meas_h_total_o  = meas_ht_q;
    assign meas_h_active_o = meas_ha_q;
    assign meas_v_total_o  = meas_vt_q;
    assign meas_v_active_o = meas_va_q;
    assign locked_o        = locked_q;
    assign fmt_err_o       = err_q;
    assign lost_lock_o     = lost_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_video_timing_rx.sv
// Bench for video_timing_rx on a scaled-down format: pixel scoreboard plus a
// per-cycle model of lock, format error and lost-lock behaviour.
module tb_video_timing_rx;
    localparam int ACTIVE_H = 8, ACTIVE_V = 6, TOTAL_H = 12, TOTAL_V = 10;
    localparam int LOCK_FRAMES = 2, CW = 12;
    localparam int HS_W = 2, H_START = 3, VS_W = 2, V_START = 3;
    localparam int PW = 2 + 2 * CW + 24;
    localparam int S_IDLE = 0, S_MEASURE = 1, S_LOCKED = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    video_timing_rx_if vid ();

    logic          pix_valid_o, sof_o, eol_o, locked_o, fmt_err_o, lost_lock_o;
    logic [7:0]    red_o, green_o, blue_o;
    logic [CW-1:0] x_o, y_o, meas_h_total_o, meas_h_active_o, meas_v_total_o, meas_v_active_o;
    logic [1:0]    dbg_state_o;

    video_timing_rx #(
        .ACTIVE_H(ACTIVE_H), .ACTIVE_V(ACTIVE_V), .TOTAL_H(TOTAL_H), .TOTAL_V(TOTAL_V),
        .LOCK_FRAMES(LOCK_FRAMES), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .video_i(vid),
        .pix_valid_o(pix_valid_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o),
        .meas_h_total_o(meas_h_total_o), .meas_h_active_o(meas_h_active_o),
        .meas_v_total_o(meas_v_total_o), .meas_v_active_o(meas_v_active_o),
        .locked_o(locked_o), .fmt_err_o(fmt_err_o), .lost_lock_o(lost_lock_o),
        .dbg_state_o(dbg_state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard
    logic [PW-1:0] exp_q[$];
    int            due_q[$];
    logic [PW-1:0] mon_w;
    int            mon_due;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("pix_extra", 1, 0);
                end else begin
                    mon_w   = exp_q.pop_front();
                    mon_due = due_q.pop_front();
                    check("pix_data", {sof_o, eol_o, x_o, y_o, red_o, green_o, blue_o}, mon_w);
                    check("pix_lat", cyc, mon_due);
                end
            end else begin
                check("pix_idle_markers", {sof_o, eol_o}, 2'b00);
            end
        end
    end

    // reference model state
    int m_state = S_IDLE;
    int m_match = 0;
    bit m_err = 1'b0;
    bit exp_lost = 1'b0;
    int n_lines = 0, act_lines = 0, last_ha = 0, exp_vt = 0, exp_va = 0, frame_pix = 0;

    task automatic model_vs();
        bit good;
        if (m_state != S_IDLE) begin
            check("meas_h_total", meas_h_total_o, TOTAL_H);
            check("meas_h_active", meas_h_active_o, last_ha);
            check("meas_v_total", meas_v_total_o, exp_vt);
            check("meas_v_active", meas_v_active_o, exp_va);
        end
        good = (last_ha == ACTIVE_H) && (exp_vt == TOTAL_V) && (exp_va == ACTIVE_V);
        case (m_state)
            S_IDLE: begin
                m_state = S_MEASURE;
                m_match = 0;
            end
            S_MEASURE: begin
                if (good) begin
                    m_err = 1'b0;
                    m_match++;
                    if (m_match == LOCK_FRAMES) m_state = S_LOCKED;
                end else begin
                    m_match = 0;
                    m_err = 1'b1;
                end
            end
            default: begin
                if (good) begin
                    m_err = 1'b0;
                end else begin
                    m_state = S_MEASURE;
                    m_match = 0;
                    m_err = 1'b1;
                    exp_lost = 1'b1;
                end
            end
        endcase
    endtask

    task automatic model_timeout();
        exp_lost = (m_state == S_LOCKED);
        m_state = S_IDLE;
        m_match = 0;
    endtask

    task automatic check_all_zero();
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_rgb", {red_o, green_o, blue_o}, 0);
        check("rst_xy", {x_o, y_o}, 0);
        check("rst_markers", {sof_o, eol_o}, 0);
        check("rst_meas_h", {meas_h_total_o, meas_h_active_o}, 0);
        check("rst_meas_v", {meas_v_total_o, meas_v_active_o}, 0);
        check("rst_status", {locked_o, fmt_err_o, lost_lock_o}, 0);
        check("rst_state", dbg_state_o, S_IDLE);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1 check_all_zero();
        m_state = S_IDLE; m_match = 0; m_err = 1'b0;
        n_lines = 0; act_lines = 0; last_ha = 0;
        exp_q.delete();
        due_q.delete();
        #1 rst = 1'b0;
    endtask

    // driver: one line of TOTAL_H cycles; inputs change 1 time unit after each rising edge
    task automatic drive_line(input int l, input int pix, input bit vs_en, input int rst_cyc);
        bit vs_line, act_line, to_line, valid;
        int x;
        vs_line  = vs_en && (l == 0);
        act_line = vs_en && (l >= V_START) && (l < V_START + ACTIVE_V);
        to_line  = 1'b0;
        for (int c = 0; c < TOTAL_H; c++) begin
            @(posedge clk);
            #1;
            exp_lost = 1'b0;
            if (vs_line && c == 1) model_vs();
            if (to_line && c == 2) model_timeout();
            check("locked", locked_o, m_state == S_LOCKED);
            check("lost_lock", lost_lock_o, exp_lost);
            check("fmt_err", fmt_err_o, m_err);
            check("state", dbg_state_o, m_state);
            if (c == 0) begin
                if (vs_line) begin
                    exp_vt = n_lines + 1;
                    exp_va = act_lines;
                    n_lines = 0;
                    act_lines = 0;
                    frame_pix = 0;
                end else begin
                    n_lines++;
                    to_line = (n_lines == 2 * TOTAL_V + 1);
                end
            end
            valid = act_line && (c >= H_START) && (c < H_START + pix);
            vid.hsync = (c >= HS_W);
            vid.vsync = !(vs_en && (l < VS_W));
            vid.valid = valid;
            if (valid) begin
                x = c - H_START;
                vid.red   = 8'(frame_pix);
                vid.green = 8'(x * 3);
                vid.blue  = 8'($urandom_range(0, 255));
                exp_q.push_back({(x == 0) && (act_lines == 0), x == ACTIVE_H - 1, CW'(x), CW'(act_lines),
                                 vid.red, vid.green, vid.blue});
                due_q.push_back(cyc + 1);
                frame_pix++;
                if (x == pix - 1) begin
                    act_lines++;
                    last_ha = pix;
                end
            end else begin
                vid.red = 8'h00; vid.green = 8'h00; vid.blue = 8'h00;
            end
            if (c == rst_cyc) do_reset();
        end
    endtask

    task automatic drive_frame(input int pix, input int rst_line, input int rst_cyc);
        for (int l = 0; l < TOTAL_V; l++) drive_line(l, pix, 1'b1, (l == rst_line) ? rst_cyc : -1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        vid.hsync = 1'b1; vid.vsync = 1'b1; vid.valid = 1'b0;
        vid.red = 8'h00; vid.green = 8'h00; vid.blue = 8'h00;
        #1 rst = 1'b1;
        #1 check_all_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // nominal stream: lock one cycle after the third vsync fall
        for (int f = 0; f < 4; f++) drive_frame(ACTIVE_H, -1, -1);
        // one frame with an extra active pixel per line, then relock
        drive_frame(ACTIVE_H + 1, -1, -1);
        for (int f = 0; f < 3; f++) drive_frame(ACTIVE_H, -1, -1);
        // vsync removed while locked
        for (int l = 0; l < 25; l++) drive_line(TOTAL_V - 1, 0, 1'b0, -1);
        for (int f = 0; f < 4; f++) drive_frame(ACTIVE_H, -1, -1);
        // async reset mid-line while locked, then reacquire
        drive_frame(ACTIVE_H, 5, 2);
        for (int f = 0; f < 4; f++) drive_frame(ACTIVE_H, -1, -1);

        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing_rx.md
Name: video_timing_rx

Overview:
- Receive-side counterpart of the video timing generator.
- Consumes a raw sync/DE/RGB stream, recovers per-pixel x/y coordinates, and measures line and frame geometry.
- Compares the measured geometry against the expected format and reports lock/format errors.
- Sits at the input of the capture path (e.g. ahead of the MIPI encoder or a line buffer), so downstream logic uses clean coordinates and frame/line markers.

Parameters:
ACTIVE_H, 800, expected active pixels per line
ACTIVE_V, 600, expected active lines per frame
TOTAL_H, 1056, expected clocks per line (hsync fall to hsync fall)
TOTAL_V, 628, expected lines per frame (vsync fall to vsync fall)
LOCK_FRAMES, 2, consecutive matching frames required to assert lock
CW, 12, width of all counters and measurement outputs

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-high reset
video_hsync_i  input  1  horizontal sync, active low (low = sync pulse)
video_vsync_i  input  1  vertical sync, active low
video_valid_i  input  1  data enable (horizontal and vertical active combined)
red_i/green_i/blue_i  input  8 each  pixel data
pix_valid_o  output  1  registered data enable
red_o/green_o/blue_o  output  8 each  registered pixel data
x_o  output  CW  active pixel index within line
y_o  output  CW  active line index within frame
sof_o  output  1  high with the pixel at x=0, y=0
eol_o  output  1  high with the pixel at x=ACTIVE_H-1
meas_h_total_o, meas_h_active_o, meas_v_total_o, meas_v_active_o  output  CW each  last-frame measurements
locked_o  output  1  format locked
fmt_err_o  output  1  last completed frame mismatched
lost_lock_o  output  1  one-cycle pulse on a LOCKED to MEASURE transition

Behaviour:
- Reset (async, active-high) clears everything:
  - All outputs, counters and measurement registers go to 0.
  - The FSM goes to IDLE.
  - Edge-detect registers reset to 1 (sync idle level), so no spurious edge appears after reset.
  - Reset mid-frame discards the partial frame.
- Edge detection uses one registered copy of each sync input:
  - hs_fall = prev & ~hsync; vs_fall = prev & ~vsync.
  - de_fall = prev_de & ~valid_i.
- Horizontal counter: counts clocks and restarts at 1 on hs_fall. On hs_fall, the previous count is latched into the working h_total register.
- Active pixel counter: increments on each valid cycle and is latched into the working h_active register on de_fall.
- Line counter: increments on hs_fall. Active-line counter increments on de_fall.
- On vs_fall, latch meas_* from the working registers:
  - v_total = line count.
  - v_active = active-line count.
  - Then clear the line counters.
- Counters saturate at 2^CW-1; they never wrap.
- Pixel path has 1-cycle latency. pix_valid_o, RGB, x_o, y_o, sof_o and eol_o are registered from the inputs in the same cycle.
- x/y rules:
  - x_o = 0 on the first valid cycle of a line, +1 per valid cycle, held when not valid.
  - y_o = 0 for the first active line after vs_fall, +1 per de_fall.
  - x_o and y_o saturate rather than wrap.
  - sof_o and eol_o are 0 whenever pix_valid_o is 0.
- FSM states: IDLE, MEASURE, LOCKED.
  - IDLE to MEASURE on the first vs_fall; no comparison is made at that edge.
  - In MEASURE, on each vs_fall, compare all four measurements against the parameters:
    - Match: match_cnt+1. When match_cnt reaches LOCK_FRAMES, go to LOCKED.
    - Mismatch: match_cnt = 0 and fmt_err_o = 1.
  - In LOCKED, on each vs_fall:
    - Match: fmt_err_o = 0.
    - Mismatch: go to MEASURE, match_cnt = 0, fmt_err_o = 1, lost_lock_o pulses 1 cycle.
  - Timeout: the line counter exceeding 2*TOTAL_V with no vs_fall forces IDLE from any state. Clear locked_o and match_cnt. lost_lock_o pulses if the FSM was in LOCKED.
- Output timing:
  - locked_o = (state == LOCKED), registered; it rises 1 cycle after the qualifying vs_fall.
  - fmt_err_o updates only at vs_fall (or at timeout, where it is held).
- Simultaneous events:
  - hs_fall and vs_fall in the same cycle: process the line end first, then the frame end, so the last line is counted in v_total.
  - de_fall and hs_fall in the same cycle: both take effect.

Test Plan:
- Nominal 800x600 stream (1056x628, sync widths 128/4) for 4 frames:
  - meas = 1056/800/628/600.
  - locked_o rises 1 cycle after the 3rd vs_fall.
  - fmt_err_o stays 0.
- Pixel coordinates:
  - Ramp data equal to the active pixel count.
  - First active pixel gives sof_o=1, x_o=0, y_o=0, 1 cycle after valid.
  - The 800th pixel gives eol_o=1, x_o=799.
  - Last pixel of the frame gives y_o=599.
- Lock loss: locked, then one frame with 801 active pixels.
  - At that vs_fall: fmt_err_o=1, lost_lock_o 1-cycle pulse, locked_o=0.
  - Relock after 2 further good frames.
- Sync removal: hold vsync high for 1300 lines while locked.
  - Timeout at line 1257 (>2*628): state IDLE, locked_o=0, lost_lock_o pulses once.
- Async reset mid-line while locked:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, the first vs_fall gives no comparison; lock follows after 3 frames.
- Coincident hs_fall and vs_fall on the last line: meas_v_total_o=628, not 627.
